rc_request_scheduler: RTL and testbench

Round-robin scheduler that shares the single bitstream fetch engine (AXI-master → async FIFO → ICAP path) between several requesters. Each requester posts a partial-bitstream descriptor (address, length). The scheduler grants one request at a time, launches the engine with a one-cycle length strobe, and tracks the engine's status and decouple outputs until the bitstream has fully drained into ICAP. It then reports completion to the originating requester and sits between software/hardware request sources and the fetch engine's strobe, address and status signals.

---
 rtl/rc_request_scheduler.sv | 175 +++++++++++++++++
 tb/tb_rc_request_scheduler.sv | 330 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rc_request_scheduler.sv
// Round-robin scheduler sharing one bitstream fetch engine between NUM_REQ requesters.
// Define RC_SCHED_TIMEOUT_EN to enable the watchdog on the engine handshake states.
`timescale 1ns/1ps
module rc_request_scheduler #(
  parameter int NUM_REQ        = 4,
  parameter int BS_LENGTH_BITS = 24,
  parameter int TIMEOUT_BITS   = 24,
  parameter int ID_W           = $clog2(NUM_REQ)
) (
  input  logic                              aclk,
  input  logic                              reset,
  input  logic [NUM_REQ-1:0]                req_valid,
  output logic [NUM_REQ-1:0]                req_ready,
  input  logic [NUM_REQ*32-1:0]             req_addr,
  input  logic [NUM_REQ*BS_LENGTH_BITS-1:0] req_length,
  output logic [31:0]                       rc_bs_addr,
  output logic [BS_LENGTH_BITS-1:0]         rc_bs_length_strobe,
  input  logic [1:0]                        rc_status,
  input  logic                              rc_decouple,
  output logic                              busy,
  output logic [ID_W-1:0]                   grant_id,
  output logic                              done_valid,
  output logic [ID_W-1:0]                   done_id,
  output logic                              done_error,
  output logic [TIMEOUT_BITS-1:0]           timeout_count
);

  localparam int unsigned NREQ    = NUM_REQ;
  localparam logic [1:0]  ST_BUSY = 2'd2;
  localparam logic [1:0]  ST_DONE = 2'd1;

  typedef enum logic [2:0] {
    IDLE,
    LAUNCH,
    WAIT_BUSY,
    WAIT_DONE,
    DRAIN,
    REPORT
  } state_t;

  state_t                    state;
  logic [ID_W-1:0]           last_grant;
  logic                      sel_found;
  logic [ID_W-1:0]           sel_id;
  logic [31:0]               sel_addr;
  logic [BS_LENGTH_BITS-1:0] sel_len;
  logic [TIMEOUT_BITS-1:0]   wd_next;
  logic                      wd_hit;

  // Round-robin search as two ordered passes: indices above last_grant, then the wrap-around.
  always_comb begin
    sel_found = 1'b0;
    sel_id    = '0;
    sel_addr  = '0;
    sel_len   = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (!sel_found && req_valid[i] && (i > 32'(last_grant))) begin
        sel_found = 1'b1;
        sel_id    = ID_W'(i);
        sel_addr  = req_addr[32*i +: 32];
        sel_len   = req_length[BS_LENGTH_BITS*i +: BS_LENGTH_BITS];
      end
    end
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (!sel_found && req_valid[i] && (i <= 32'(last_grant))) begin
        sel_found = 1'b1;
        sel_id    = ID_W'(i);
        sel_addr  = req_addr[32*i +: 32];
        sel_len   = req_length[BS_LENGTH_BITS*i +: BS_LENGTH_BITS];
      end
    end
  end

  always_comb begin
    req_ready = '0;
    if (!reset && (state == IDLE) && sel_found) begin
      req_ready[sel_id] = 1'b1;
    end
  end

`ifdef RC_SCHED_TIMEOUT_EN
  assign wd_next = (timeout_count == '1) ? timeout_count : timeout_count + TIMEOUT_BITS'(1);
  assign wd_hit  = (wd_next == '1);
`else
  assign wd_next = '0;
  assign wd_hit  = 1'b0;
`endif

  always_ff @(posedge aclk) begin
    if (reset) begin
      state               <= IDLE;
      last_grant          <= ID_W'(NUM_REQ - 1);
      rc_bs_addr          <= '0;
      rc_bs_length_strobe <= '0;
      busy                <= 1'b0;
      grant_id            <= '0;
      done_valid          <= 1'b0;
      done_id             <= '0;
      done_error          <= 1'b0;
      timeout_count       <= '0;
    end else begin
      rc_bs_length_strobe <= '0;
      done_valid          <= 1'b0;
      case (state)
        IDLE: begin
          if (sel_found) begin
            rc_bs_addr <= sel_addr;
            grant_id   <= sel_id;
            busy       <= 1'b1;
            if (sel_len != '0) begin
              state               <= LAUNCH;
              rc_bs_length_strobe <= sel_len;
            end else begin
              // Zero length never reaches the engine; report straight away as an error.
              state      <= REPORT;
              done_valid <= 1'b1;
              done_id    <= sel_id;
              done_error <= 1'b1;
            end
          end
        end
        LAUNCH: begin
          timeout_count <= '0;
          state         <= WAIT_BUSY;
        end
        WAIT_BUSY: begin
          timeout_count <= wd_next;
          if (rc_status == ST_BUSY) begin
            state <= WAIT_DONE;
          end else if (wd_hit) begin
            state      <= REPORT;
            done_valid <= 1'b1;
            done_id    <= grant_id;
            done_error <= 1'b1;
          end
        end
        WAIT_DONE: begin
          timeout_count <= wd_next;
          if (rc_status == ST_DONE) begin
            state <= DRAIN;
          end else if (wd_hit) begin
            state      <= REPORT;
            done_valid <= 1'b1;
            done_id    <= grant_id;
            done_error <= 1'b1;
          end
        end
        DRAIN: begin
          timeout_count <= wd_next;
          if (!rc_decouple) begin
            state      <= REPORT;
            done_valid <= 1'b1;
            done_id    <= grant_id;
            done_error <= 1'b0;
          end else if (wd_hit) begin
            state      <= REPORT;
            done_valid <= 1'b1;
            done_id    <= grant_id;
            done_error <= 1'b1;
          end
        end
        REPORT: begin
          last_grant <= grant_id;
          busy       <= 1'b0;
          state      <= IDLE;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rc_request_scheduler.sv
// Scoreboard bench for rc_request_scheduler: a round-robin reference model predicts grants,
// strobes and completions; a separate monitor compares what the DUT presents.
`timescale 1ns/1ps
module tb_rc_request_scheduler;
  localparam int NR = 4;
  localparam int LB = 24;
  localparam int TB = 4;
  localparam int IW = 2;

  logic               aclk = 1'b0;
  logic               reset = 1'b1;
  logic [NR-1:0]      req_valid = '0;
  logic [NR-1:0]      req_ready;
  logic [NR*32-1:0]   req_addr = '0;
  logic [NR*LB-1:0]   req_length = '0;
  logic [31:0]        rc_bs_addr;
  logic [LB-1:0]      rc_bs_length_strobe;
  logic [1:0]         rc_status = 2'd0;
  logic               rc_decouple = 1'b0;
  logic               busy;
  logic [IW-1:0]      grant_id;
  logic               done_valid;
  logic [IW-1:0]      done_id;
  logic               done_error;
  logic [TB-1:0]      timeout_count;

  rc_request_scheduler #(
    .NUM_REQ(NR), .BS_LENGTH_BITS(LB), .TIMEOUT_BITS(TB), .ID_W(IW)
  ) dut (
    .aclk(aclk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
    .req_addr(req_addr), .req_length(req_length), .rc_bs_addr(rc_bs_addr),
    .rc_bs_length_strobe(rc_bs_length_strobe), .rc_status(rc_status),
    .rc_decouple(rc_decouple), .busy(busy), .grant_id(grant_id),
    .done_valid(done_valid), .done_id(done_id), .done_error(done_error),
    .timeout_count(timeout_count)
  );

  always #5 aclk = ~aclk;

  typedef struct { int id; bit err; int cyc; } done_t;
  typedef struct { logic [LB-1:0] len; logic [31:0] addr; int cyc; } strb_t;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  done_t exp_done[$];
  strb_t exp_strb[$];
  int grant_log[$];
  bit m_idle = 1'b1;
  int m_last = NR - 1;
  bit exp_to = 1'b0;
  logic [NR-1:0] hs = '0;
  bit st_seen = 1'b0;
  int done_cnt = 0;
  bit rnd_en = 1'b0;
  bit eng_en = 1'b0;
  bit [NR-1:0] hold = '0;
  int cool [NR];
  int eph = 0;
  int ecnt = 0;

  always @(posedge aclk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference model: pending requests and the last grant decide the next winner.
  always @(negedge aclk) begin : model
    logic [NR-1:0] er;
    int pick;
    logic [LB-1:0] l;
    if (reset) begin
      exp_done.delete();
      exp_strb.delete();
      m_idle = 1'b1;
      m_last = NR - 1;
      chk("ready_in_reset", req_ready, 0);
    end else begin
      er = '0;
      pick = -1;
      if (m_idle) begin
        for (int k = 1; k <= NR; k++)
          if (pick < 0 && req_valid[(m_last + k) % NR]) pick = (m_last + k) % NR;
        if (pick >= 0) er[pick] = 1'b1;
      end
      chk("req_ready", req_ready, er);
      chk("busy", busy, !m_idle);
      if (!m_idle) chk("grant_id", grant_id, m_last);
      if (pick >= 0) begin
        l = req_length[pick*LB +: LB];
        grant_log.push_back(pick);
        m_idle = 1'b0;
        m_last = pick;
        if (l == 0) begin
          exp_done.push_back('{pick, 1'b1, cyc + 1});
        end else begin
          exp_strb.push_back('{l, req_addr[pick*32 +: 32], cyc + 1});
          exp_done.push_back('{pick, exp_to, exp_to ? cyc + 2 + (1 << TB) - 1 : 0});
        end
      end
      if (done_valid) m_idle = 1'b1;
    end
  end

  always @(negedge aclk) begin : monitor
    strb_t s;
    done_t d;
    hs = reset ? '0 : req_ready;
    st_seen = !reset && (rc_bs_length_strobe != '0);
    if (!reset) begin
      if (rc_bs_length_strobe != '0) begin
        if (exp_strb.size() == 0) begin
          checks++; errors++;
          $display("FAIL strobe_unexpected: got %0h expected 0 (cycle %0d)", rc_bs_length_strobe, cyc);
        end else begin
          s = exp_strb.pop_front();
          chk("strobe_len", rc_bs_length_strobe, s.len);
          chk("bs_addr", rc_bs_addr, s.addr);
          chk("strobe_cycle", cyc, s.cyc);
        end
      end
      if (done_valid) begin
        done_cnt++;
        if (exp_done.size() == 0) begin
          checks++; errors++;
          $display("FAIL done_unexpected: got done_id %0d expected no completion (cycle %0d)", done_id, cyc);
        end else begin
          d = exp_done.pop_front();
          chk("done_id", done_id, d.id);
          chk("done_error", done_error, d.err);
          if (d.cyc != 0) chk("done_cycle", cyc, d.cyc);
        end
      end
    end
  end

  task automatic post(input int i, input logic [31:0] a, input logic [LB-1:0] l);
    req_addr[i*32 +: 32] = a;
    req_length[i*LB +: LB] = l;
    req_valid[i] = 1'b1;
  endtask

  // One clock of stimulus: requester handshakes/random posts, then the engine model.
  task automatic tick();
    logic [LB-1:0] l;
    @(posedge aclk);
    #1;
    for (int i = 0; i < NR; i++) begin
      if (hs[i] && !hold[i]) begin
        req_valid[i] = 1'b0;
        cool[i] = $urandom_range(0, 5);
      end else if (rnd_en) begin
        if (!req_valid[i]) begin
          if (cool[i] > 0) cool[i]--;
          else if ($urandom_range(0, 3) == 0) begin
            l = ($urandom_range(0, 5) == 0) ? '0 : LB'($urandom_range(1, 512) * 8);
            post(i, $urandom & 32'hFFFF_FFF8, l);
          end
        end else if (!hs[i] && $urandom_range(0, 49) == 0) begin
          req_valid[i] = 1'b0;
        end
      end
    end
    if (eng_en) begin
      case (eph)
        0: if (st_seen) begin rc_decouple = 1'b1; ecnt = $urandom_range(1, 3); eph = 1; end
        1: begin
          ecnt--;
          if (ecnt == 0) begin rc_status = 2'd2; ecnt = $urandom_range(1, 4); eph = 2; end
        end
        2: begin
          ecnt--;
          if (ecnt == 0) begin
            rc_status = 2'd1;
            ecnt = $urandom_range(0, 4);
            eph = 3;
            if (ecnt == 0) begin rc_decouple = 1'b0; eph = 0; end
          end
        end
        default: begin
          ecnt--;
          if (ecnt == 0) begin rc_decouple = 1'b0; eph = 0; end
        end
      endcase
    end
  endtask

  task automatic wait_idle(input string name, input int budget);
    int n;
    n = 0;
    while (!(m_idle && exp_done.size() == 0 && req_valid == '0 && eph == 0) && n < budget) begin
      tick();
      n++;
    end
    checks++;
    if (n >= budget) begin
      errors++;
      $display("FAIL %s_drain: still pending after %0d cycles, expected idle (busy=%0b)", name, n, busy);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: simulation exceeded time bound, expected completion");
    $fatal(1, "time bound exceeded");
  end

  initial begin : main
    int base;
    int dc;
    for (int i = 0; i < NR; i++) cool[i] = 0;

    repeat (3) tick();
    @(negedge aclk);
    chk("rst_req_ready", req_ready, 0);
    chk("rst_bs_addr", rc_bs_addr, 0);
    chk("rst_strobe", rc_bs_length_strobe, 0);
    chk("rst_busy", busy, 0);
    chk("rst_grant_id", grant_id, 0);
    chk("rst_done_valid", done_valid, 0);
    chk("rst_done_id", done_id, 0);
    chk("rst_done_error", done_error, 0);
    chk("rst_timeout_count", timeout_count, 0);

    // Single request
    eng_en = 1'b1;
    tick();
    reset = 1'b0;
    post(0, 32'h1000_0000, 24'h400);
    wait_idle("single", 100);

    // Contention: all four valid out of reset
    reset = 1'b1;
    for (int i = 0; i < NR; i++) post(i, 32'h2000_0000 + 32'(i) * 32'h1000, 24'h80);
    tick(); tick();
    base = grant_log.size();
    reset = 1'b0;
    wait_idle("contention", 300);
    chk("contention_count", grant_log.size() - base, 4);
    if (grant_log.size() >= base + 4)
      for (int k = 0; k < 4; k++) chk("contention_order", grant_log[base + k], k);

    // Fairness: req1 held, req3 joins after the first grant
    reset = 1'b1;
    tick();
    reset = 1'b0;
    base = grant_log.size();
    hold[1] = 1'b1;
    post(1, 32'h2100_0000, 24'h80);
    for (int n = 0; n < 20 && grant_log.size() < base + 1; n++) tick();
    post(3, 32'h2300_0000, 24'h80);
    for (int n = 0; n < 200 && grant_log.size() < base + 3; n++) tick();
    hold[1] = 1'b0;
    req_valid[1] = 1'b0;
    wait_idle("fairness", 200);
    chk("fair_count", grant_log.size() - base, 3);
    if (grant_log.size() >= base + 3) begin
      chk("fair_grant0", grant_log[base], 1);
      chk("fair_grant1", grant_log[base + 1], 3);
      chk("fair_grant2", grant_log[base + 2], 1);
    end

    // Zero length
    post(2, 32'h3000_0000, '0);
    wait_idle("zero_len", 50);

    // Stale done status with an engine that never reports busy
    eng_en = 1'b0;
    rc_status = 2'd1;
    rc_decouple = 1'b0;
    dc = done_cnt;
`ifdef RC_SCHED_TIMEOUT_EN
    exp_to = 1'b1;
    post(2, 32'h4000_0000, 24'h100);
    for (int n = 0; n < 60 && done_cnt == dc; n++) tick();
    exp_to = 1'b0;
    chk("timeout_done", done_cnt - dc, 1);
    chk("timeout_count_sat", timeout_count, 4'hF);
    wait_idle("timeout", 50);
`else
    post(2, 32'h4000_0000, 24'h100);
    repeat (1000) tick();
    chk("no_done_without_watchdog", done_cnt - dc, 0);
    chk("timeout_count_tied", timeout_count, 0);
    chk("busy_while_stuck", busy, 1);
    rc_status = 2'd2;
    tick(); tick();
    rc_status = 2'd1;
    wait_idle("stuck_release", 50);
`endif

    // Reset while draining
    post(0, 32'h5000_0000, 24'h40);
    base = grant_log.size();
    for (int n = 0; n < 10 && grant_log.size() <= base; n++) tick();
    rc_decouple = 1'b1;
    tick();
    rc_status = 2'd2;
    tick();
    rc_status = 2'd1;
    tick(); tick();
    chk("in_drain_busy", busy, 1);
    reset = 1'b1;
    post(1, 32'h6000_0000, 24'h88);
    tick();
    reset = 1'b0;
    @(negedge aclk);
    chk("post_reset_busy", busy, 0);
    chk("post_reset_no_done", done_valid, 0);
    chk("post_reset_accept", req_ready, 4'b0010);
    eng_en = 1'b1;
    wait_idle("reset_drain", 100);

    // Randomized traffic
    rnd_en = 1'b1;
    repeat (3000) tick();
    rnd_en = 1'b0;
    wait_idle("random", 500);
    chk("queues_empty", exp_done.size() + exp_strb.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
